// File: rtl/md_pkg.sv
// Shared types and defaults for the multiply/divide sequencer.
// Build option MD_DIV0_GUARD_EN is consumed by md_sched.
package md_pkg;

  typedef enum logic [2:0] {
    MULT  = 3'd0,
    MULTU = 3'd1,
    DIV   = 3'd2,
    DIVU  = 3'd3,
    MTHI  = 3'd4,
    MTLO  = 3'd5
  } md_op_t;

  typedef logic [0:0] state_t;
  localparam state_t IDLE = 1'b0;
  localparam state_t RUN  = 1'b1;

  localparam int MULT_CYCLES_DEF = 5;
  localparam int DIV_CYCLES_DEF  = 10;
  localparam int CNT_W_DEF       = 4;

  function automatic logic is_arith(input md_op_t op);
    return (op == MULT) || (op == MULTU) || (op == DIV) || (op == DIVU);
  endfunction

endpackage

// File: rtl/md_arith.sv
// Combinational multiply/divide datapath on latched operands.
// result = {hi, lo}; divide-by-zero yields {dividend, all-ones}.
module md_arith
  import md_pkg::*;
(
  input  md_op_t      op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic [63:0] result
);

  logic signed [63:0] prod_s;
  logic [63:0]        prod_u;
  logic               is_sdiv;
  logic [31:0]        num;
  logic [31:0]        den;
  logic [31:0]        quo;
  logic [31:0]        rem;

  // Signed divide runs on magnitudes; 0x80000000 / -1 falls out as 0x80000000 rem 0.
  always_comb begin
    prod_s  = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b});
    prod_u  = {32'd0, a} * {32'd0, b};
    is_sdiv = (op == DIV);
    num     = (is_sdiv && a[31]) ? -a : a;
    den     = (is_sdiv && b[31]) ? -b : b;
    quo     = '0;
    rem     = '0;
    if (den != 32'd0) begin
      quo = num / den;
      rem = num % den;
    end
    if (is_sdiv) begin
      if (a[31] ^ b[31]) quo = -quo;
      if (a[31]) rem = -rem;
    end
    result = '0;
    case (op)
      MULT:      result = prod_s;
      MULTU:     result = prod_u;
      DIV, DIVU: result = (b == 32'd0) ? {a, 32'hFFFF_FFFF} : {rem, quo};
      default:   result = '0;
    endcase
  end

endmodule

// File: rtl/md_sched.sv
// Multiply/divide sequencer: FSM, latency counter and HI/LO ownership.
// Build option MD_DIV0_GUARD_EN: divide by zero ends in one cycle, HI/LO kept, div0 pulses.
//
// state | meaning
// IDLE  | no computation; MTHI/MTLO write HI/LO directly
// RUN   | computation in flight, cnt counts down to the commit cycle
module md_sched
  import md_pkg::*;
#(
  parameter int MULT_CYCLES = MULT_CYCLES_DEF,
  parameter int DIV_CYCLES  = DIV_CYCLES_DEF,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  md_op_t      op,
  input  logic [31:0] rs_val,
  input  logic [31:0] rt_val,
  input  logic        md_use,
  output logic        busy,
  output logic        stall_req,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  state_t           state;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] load_cnt;
  md_op_t           op_q;
  logic [31:0]      a_q;
  logic [31:0]      b_q;
  logic [63:0]      result;
  logic             start_md;
  logic             last;
  logic             commit;

  md_arith u_arith (
    .op     (op_q),
    .a      (a_q),
    .b      (b_q),
    .result (result)
  );

  assign start_md  = start & is_arith(op);
  assign busy      = (state == RUN);
  assign last      = busy && (cnt == CNT_W'(1));
  assign done      = last;
  assign stall_req = md_use & (busy | start_md);

`ifdef MD_DIV0_GUARD_EN
  logic div_zero;
  logic zdiv_q;

  assign div_zero = ((op == DIV) || (op == DIVU)) && (rt_val == 32'd0);
  assign load_cnt = div_zero ? CNT_W'(1) :
                    ((op == MULT) || (op == MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
  assign commit   = last & ~zdiv_q;
  assign div0     = last & zdiv_q;

  always_ff @(posedge clk) begin
    if (!reset)                         zdiv_q <= 1'b0;
    else if ((state == IDLE) && start_md) zdiv_q <= div_zero;
  end
`else
  assign load_cnt = ((op == MULT) || (op == MULTU)) ? CNT_W'(MULT_CYCLES) : CNT_W'(DIV_CYCLES);
  assign commit   = last;
  assign div0     = 1'b0;
`endif

  // Any start seen while RUN is dropped; the pipeline re-presents it via stall_req.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state <= IDLE;
      cnt   <= '0;
      op_q  <= MULT;
      a_q   <= '0;
      b_q   <= '0;
      hi    <= '0;
      lo    <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start_md) begin
            state <= RUN;
            cnt   <= load_cnt;
            op_q  <= op;
            a_q   <= rs_val;
            b_q   <= rt_val;
          end else if (start && (op == MTHI)) begin
            hi <= rs_val;
          end else if (start && (op == MTLO)) begin
            lo <= rs_val;
          end
        end
        RUN: begin
          cnt <= cnt - CNT_W'(1);
          if (cnt == CNT_W'(1)) state <= IDLE;
          if (commit) {hi, lo} <= result;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_md_sched.sv
// Self-checking bench for md_sched: directed cases plus randomized ops against an
// arithmetic reference model. Honours MD_DIV0_GUARD_EN like the design.
module tb_md_sched;
  import md_pkg::*;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        start = 1'b0;
  md_op_t      op = MULT;
  logic [31:0] rs_val = '0;
  logic [31:0] rt_val = '0;
  logic        md_use = 1'b0;
  logic        busy, stall_req, done, div0;
  logic [31:0] hi, lo;

  int nvec = 0;
  int nfail = 0;
  bit allow_busy_start = 1'b0;
  logic [31:0] m_hi = '0;
  logic [31:0] m_lo = '0;

  md_sched dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .op        (op),
    .rs_val    (rs_val),
    .rt_val    (rt_val),
    .md_use    (md_use),
    .busy      (busy),
    .stall_req (stall_req),
    .done      (done),
    .div0      (div0),
    .hi        (hi),
    .lo        (lo)
  );

  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (start && busy && !allow_busy_start) begin
      nfail++;
      $display("FAIL start_while_busy: start=%0b busy=%0b, required no start while busy", start, busy);
    end
  end

  initial begin
    #500000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1, "timeout");
  end

  // Reference: new {h,l}, busy cycles n and div0 pulses z, from the architectural rules.
  function automatic void ref_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                                 inout logic [31:0] h, inout logic [31:0] l,
                                 output int n, output int z);
    longint sa, sb, sq, sr;
    longint unsigned ua, ub, uq, ur, p;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'd0, a};
    ub = {32'd0, b};
    z = 0;
    n = 0;
    case (o)
      3'd0: begin p = sa * sb; h = p[63:32]; l = p[31:0]; n = 5; end
      3'd1: begin p = ua * ub; h = p[63:32]; l = p[31:0]; n = 5; end
      3'd2, 3'd3: begin
        if (b == 32'd0) begin
`ifdef MD_DIV0_GUARD_EN
          n = 1; z = 1;
`else
          h = a; l = 32'hFFFF_FFFF; n = 10;
`endif
        end else if (o == 3'd2) begin
          sq = sa / sb; sr = sa % sb;
          h = sr[31:0]; l = sq[31:0]; n = 10;
        end else begin
          uq = ua / ub; ur = ua % ub;
          h = ur[31:0]; l = uq[31:0]; n = 10;
        end
      end
      3'd4: h = a;
      3'd5: l = a;
      default: n = 0;
    endcase
  endfunction

  // Issue one op for one cycle, then observe until the unit is idle again.
  task automatic do_op(input logic [2:0] o, input logic [31:0] a, input logic [31:0] b,
                       output int nb, output int dn_at, output int ndone, output int nz);
    @(posedge clk); #1;
    start = 1'b1; op = md_op_t'(o); rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0; rs_val = $urandom; rt_val = $urandom;
    nb = 0; dn_at = 0; ndone = 0; nz = 0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (busy) nb++;
      if (done) begin ndone++; dn_at = nb; end
      if (div0) nz++;
      if (!busy) break;
      if (k == 39) nb = -1;
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    nvec++;
    if ({busy, done, div0, stall_req} !== 4'b0000) begin
      nfail++;
      $display("FAIL reset_flags: busy/done/div0/stall=%b, required 0000", {busy, done, div0, stall_req});
    end
    nvec++;
    if ({hi, lo} !== 64'd0) begin
      nfail++;
      $display("FAIL reset_hilo: hi=%h lo=%h, required 0/0", hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
  endtask

  task automatic test_mult();
    int nb, dn, nd, nz, en, ez;
    ref_op(3'd0, 32'hFFFF_FFFF, 32'd2, m_hi, m_lo, en, ez);
    do_op(3'd0, 32'hFFFF_FFFF, 32'd2, nb, dn, nd, nz);
    nvec++;
    if (nb !== 5 || dn !== 5 || nd !== 1) begin
      nfail++;
      $display("FAIL mult_timing: busy=%0d done_at=%0d dones=%0d, required 5/5/1", nb, dn, nd);
    end
    nvec++;
    if (hi !== 32'hFFFF_FFFF || lo !== 32'hFFFF_FFFE) begin
      nfail++;
      $display("FAIL mult_result: hi=%h lo=%h, required ffffffff/fffffffe", hi, lo);
    end
    ref_op(3'd1, 32'hFFFF_FFFF, 32'd2, m_hi, m_lo, en, ez);
    do_op(3'd1, 32'hFFFF_FFFF, 32'd2, nb, dn, nd, nz);
    nvec++;
    if (nb !== 5 || hi !== 32'h0000_0001 || lo !== 32'hFFFF_FFFE) begin
      nfail++;
      $display("FAIL multu: busy=%0d hi=%h lo=%h, required 5/00000001/fffffffe", nb, hi, lo);
    end
  endtask

  task automatic test_div();
    int nb, dn, nd, nz, en, ez;
    ref_op(3'd2, 32'hFFFF_FFF9, 32'd2, m_hi, m_lo, en, ez);
    do_op(3'd2, 32'hFFFF_FFF9, 32'd2, nb, dn, nd, nz);
    nvec++;
    if (nb !== 10 || dn !== 10 || nd !== 1) begin
      nfail++;
      $display("FAIL div_timing: busy=%0d done_at=%0d dones=%0d, required 10/10/1", nb, dn, nd);
    end
    nvec++;
    if (lo !== 32'hFFFF_FFFD || hi !== 32'hFFFF_FFFF) begin
      nfail++;
      $display("FAIL div_signed: hi=%h lo=%h, required ffffffff/fffffffd", hi, lo);
    end
    ref_op(3'd3, 32'd7, 32'd2, m_hi, m_lo, en, ez);
    do_op(3'd3, 32'd7, 32'd2, nb, dn, nd, nz);
    nvec++;
    if (lo !== 32'd3 || hi !== 32'd1) begin
      nfail++;
      $display("FAIL divu: hi=%h lo=%h, required 1/3", hi, lo);
    end
    ref_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, m_hi, m_lo, en, ez);
    do_op(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, nb, dn, nd, nz);
    nvec++;
    if (lo !== 32'h8000_0000 || hi !== 32'd0) begin
      nfail++;
      $display("FAIL div_overflow: hi=%h lo=%h, required 0/80000000", hi, lo);
    end
  endtask

  task automatic test_mthi_mtlo();
    int nb, dn, nd, nz, en, ez;
    ref_op(3'd4, 32'hAAAA_5555, 32'd9, m_hi, m_lo, en, ez);
    do_op(3'd4, 32'hAAAA_5555, 32'd9, nb, dn, nd, nz);
    nvec++;
    if (nb !== 0 || nd !== 0 || hi !== 32'hAAAA_5555 || lo !== m_lo) begin
      nfail++;
      $display("FAIL mthi: busy=%0d dones=%0d hi=%h lo=%h, required 0/0/aaaa5555/%h", nb, nd, hi, lo, m_lo);
    end
    ref_op(3'd5, 32'h1234_5678, 32'd9, m_hi, m_lo, en, ez);
    do_op(3'd5, 32'h1234_5678, 32'd9, nb, dn, nd, nz);
    nvec++;
    if (nb !== 0 || nd !== 0 || lo !== 32'h1234_5678 || hi !== 32'hAAAA_5555) begin
      nfail++;
      $display("FAIL mtlo: busy=%0d dones=%0d hi=%h lo=%h, required 0/0/aaaa5555/12345678", nb, nd, hi, lo);
    end
  endtask

  task automatic test_div0();
    int nb, dn, nd, nz, en, ez;
    for (int i = 0; i < 2; i++) begin
      logic [2:0] o;
      o = (i == 0) ? 3'd2 : 3'd3;
      ref_op(o, 32'h0000_1357, 32'd0, m_hi, m_lo, en, ez);
      do_op(o, 32'h0000_1357, 32'd0, nb, dn, nd, nz);
`ifdef MD_DIV0_GUARD_EN
      nvec++;
      if (nb !== 1 || dn !== 1 || nz !== 1) begin
        nfail++;
        $display("FAIL div0_guard_timing: busy=%0d done_at=%0d div0=%0d, required 1/1/1", nb, dn, nz);
      end
      nvec++;
      if (hi !== 32'hAAAA_5555 || lo !== 32'h1234_5678) begin
        nfail++;
        $display("FAIL div0_guard_hilo: hi=%h lo=%h, required aaaa5555/12345678", hi, lo);
      end
`else
      nvec++;
      if (nb !== 10 || dn !== 10 || nz !== 0) begin
        nfail++;
        $display("FAIL div0_timing: busy=%0d done_at=%0d div0=%0d, required 10/10/0", nb, dn, nz);
      end
      nvec++;
      if (hi !== 32'h0000_1357 || lo !== 32'hFFFF_FFFF) begin
        nfail++;
        $display("FAIL div0_hilo: hi=%h lo=%h, required 00001357/ffffffff", hi, lo);
      end
`endif
    end
  endtask

  task automatic test_stall();
    int en, ez;
    logic [31:0] a, b;
    a = $urandom; b = $urandom;
    md_use = 1'b1;
    @(negedge clk);
    nvec++;
    if (stall_req !== 1'b0) begin
      nfail++;
      $display("FAIL stall_idle: stall_req=%b, required 0", stall_req);
    end
    ref_op(3'd0, a, b, m_hi, m_lo, en, ez);
    @(posedge clk); #1;
    start = 1'b1; op = MULT; rs_val = a; rt_val = b;
    @(negedge clk);
    nvec++;
    if (stall_req !== 1'b1) begin
      nfail++;
      $display("FAIL stall_start: stall_req=%b, required 1", stall_req);
    end
    @(posedge clk); #1;
    start = 1'b0;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      nvec++;
      if (stall_req !== (k <= 5)) begin
        nfail++;
        $display("FAIL stall_cycle%0d: stall_req=%b, required %b", k, stall_req, (k <= 5));
      end
    end
    nvec++;
    if ({hi, lo} !== {m_hi, m_lo}) begin
      nfail++;
      $display("FAIL stall_result: hi=%h lo=%h, required %h/%h", hi, lo, m_hi, m_lo);
    end
    md_use = 1'b0;
  endtask

  task automatic test_reset_mid();
    int nb, dn, nd, nz, en, ez, dcount;
    ref_op(3'd4, 32'h0000_1234, 32'd0, m_hi, m_lo, en, ez);
    do_op(3'd4, 32'h0000_1234, 32'd0, nb, dn, nd, nz);
    @(posedge clk); #1;
    start = 1'b1; op = DIV; rs_val = 32'd1000; rt_val = 32'd3;
    @(posedge clk); #1;
    start = 1'b0;
    dcount = 0;
    repeat (4) begin
      @(negedge clk);
      if (done) dcount++;
    end
    reset = 1'b0;
    @(negedge clk);
    if (done) dcount++;
    nvec++;
    if (busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) begin
      nfail++;
      $display("FAIL reset_mid: busy=%b hi=%h lo=%h, required 0/0/0", busy, hi, lo);
    end
    @(posedge clk); #1;
    reset = 1'b1;
    m_hi = '0; m_lo = '0;
    repeat (12) begin
      @(negedge clk);
      if (done || busy) dcount++;
    end
    nvec++;
    if (dcount !== 0) begin
      nfail++;
      $display("FAIL reset_mid_nodone: done/busy cycles=%0d, required 0", dcount);
    end
  endtask

  task automatic test_back_to_back();
    int en, ez, en2, ez2, nb, k;
    logic [31:0] a, b;
    logic [31:0] h1, l1;
    a = $urandom; b = $urandom;
    ref_op(3'd0, a, b, m_hi, m_lo, en, ez);
    h1 = m_hi; l1 = m_lo;
    @(posedge clk); #1;
    start = 1'b1; op = MULT; rs_val = a; rt_val = b;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done && k < 20);
    nvec++;
    if (k !== 5) begin
      nfail++;
      $display("FAIL b2b_first_done: done_at=%0d, required 5", k);
    end
    allow_busy_start = 1'b1;
    start = 1'b1; op = DIVU; rs_val = 32'd100; rt_val = 32'd7;
    @(posedge clk); #1;
    @(negedge clk);
    nvec++;
    if (busy !== 1'b0 || hi !== h1 || lo !== l1) begin
      nfail++;
      $display("FAIL b2b_ignored: busy=%b hi=%h lo=%h, required 0/%h/%h", busy, hi, lo, h1, l1);
    end
    ref_op(3'd3, 32'd100, 32'd7, m_hi, m_lo, en2, ez2);
    @(posedge clk); #1;
    start = 1'b0;
    allow_busy_start = 1'b0;
    nb = 0;
    for (int j = 0; j < 40; j++) begin
      @(negedge clk);
      if (!busy) break;
      nb++;
    end
    nvec++;
    if (nb !== en2 || lo !== 32'd14 || hi !== 32'd2) begin
      nfail++;
      $display("FAIL b2b_second: busy=%0d hi=%h lo=%h, required %0d/2/14", nb, hi, lo, en2);
    end
  endtask

  task automatic test_random();
    int nb, dn, nd, nz, en, ez;
    logic [2:0] o;
    logic [31:0] a, b;
    for (int i = 0; i < 60; i++) begin
      o = 3'($urandom_range(0, 5));
      a = $urandom;
      b = $urandom;
      case ($urandom_range(0, 7))
        0: b = 32'd0;
        1: begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
        2: begin a = $urandom_range(0, 50) - 25; b = $urandom_range(1, 9); end
        3: b = -($urandom_range(1, 9));
        default: ;
      endcase
      ref_op(o, a, b, m_hi, m_lo, en, ez);
      do_op(o, a, b, nb, dn, nd, nz);
      nvec++;
      if (nb !== en) begin
        nfail++;
        $display("FAIL rand%0d_busy op=%0d: busy=%0d, required %0d", i, o, nb, en);
      end
      nvec++;
      if (nd !== ((en > 0) ? 1 : 0) || dn !== en) begin
        nfail++;
        $display("FAIL rand%0d_done op=%0d: dones=%0d at=%0d, required %0d at %0d", i, o, nd, dn, (en > 0) ? 1 : 0, en);
      end
      nvec++;
      if (nz !== ez) begin
        nfail++;
        $display("FAIL rand%0d_div0 op=%0d: div0=%0d, required %0d", i, o, nz, ez);
      end
      nvec++;
      if ({hi, lo} !== {m_hi, m_lo}) begin
        nfail++;
        $display("FAIL rand%0d_hilo op=%0d a=%h b=%h: hi=%h lo=%h, required %h/%h", i, o, a, b, hi, lo, m_hi, m_lo);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo();
    test_div0();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
